// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between four requesters, the arbiter and the downstream encoder.
// Latency: none, wires only.
// Backpressure: none; requesters hold req high until they see their grant bit.
interface rr_req_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;

  // Arbiter side: samples requests and drives the registered grant outputs.
  modport master (
    input  req,
    output grant,
    output grant_valid,
    output timeout
  );

  // Requester/encoder side.
  modport slave (
    output req,
    input  grant,
    input  grant_valid,
    input  timeout
  );
endinterface

// File: rtl/rr_req_arbiter.sv
// Four-way round-robin arbiter with a minimum grant hold, one idle gap cycle between grants, optional watchdog (ARB_TIMEOUT_EN).
// Latency: a req sampled at edge N in IDLE/GAP is granted after edge N; all outputs are registered.
// Backpressure: a held grant is never preempted; the others wait until the holder releases (or the watchdog fires).
module rr_req_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_GRANT   = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_req_arbiter_if.master arb
);

  localparam int CW = $clog2(MAX_GRANT + 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;
  localparam logic [1:0] GAP  = 2'b10;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic [1:0]    state;
  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic [CW-1:0] hold_cnt;
  logic [3:0]    grant_q;
  logic          grant_valid_q;

  logic          any_req;
  logic [1:0]    win_idx;
  logic [1:0]    cand;
  logic          release_ok;

  // First requesting index at or after ptr; the lowest offset is written last so it wins.
  always_comb begin
    any_req = |arb.req;
    win_idx = ptr;
    cand    = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (arb.req[cand]) begin
        win_idx = cand;
      end
    end
  end

  // The holder may leave HOLD only once the minimum hold has run and its request is gone.
  assign release_ok = (hold_cnt >= HOLD_LAST) && !arb.req[owner];

`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GRANT - 1);
  logic timeout_q;
`endif

  // Grant state machine: arbitrate in IDLE/GAP, hold the winner, then force one empty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      owner         <= 2'd0;
      hold_cnt      <= '0;
      grant_q       <= 4'b0000;
      grant_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            grant_q       <= 4'b0001 << win_idx;
            grant_valid_q <= 1'b1;
            owner         <= win_idx;
            ptr           <= win_idx + 2'd1;
            hold_cnt      <= '0;
            state         <= HOLD;
          end else begin
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            state         <= IDLE;
          end
        end
        HOLD: begin
          if (release_ok) begin
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            state         <= GAP;
          end
`ifdef ARB_TIMEOUT_EN
          // A requester that never lets go loses the grant; ptr already points past it.
          else if (hold_cnt >= MAX_LAST) begin
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b1;
            state         <= GAP;
          end
`endif
          else if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          grant_q       <= 4'b0000;
          grant_valid_q <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_valid = grant_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign arb.timeout     = timeout_q;
`else
  assign arb.timeout     = 1'b0;
`endif

endmodule

// File: doc/rr_req_arbiter.md
# rr_req_arbiter

Four-way round-robin request arbiter sitting directly upstream of the 4-to-2 encoder stage. Collects four independent request lines, grants exactly one at a time with rotating priority, and drives a registered one-hot grant vector whose bits feed the encoder's `a`/`b`/`c`/`d` inputs. A minimum grant hold time prevents encoder output glitches. An optional watchdog revokes a grant held too long.

## Interface
- `HOLD_CYCLES`, default 4: minimum cycles a grant stays asserted; legal range 1..15.
- `MAX_GRANT`, default 16: watchdog limit in cycles; must be ≥ `HOLD_CYCLES`; used only with `ARB_TIMEOUT_EN`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: request lines; `req[0]`..`req[3]` correspond to encoder inputs `a`..`d`.
- `grant` out 4: registered one-hot grant, or 4'b0000 when no grant is active.
- `grant_valid` out 1: high exactly when `grant` ≠ 0.
- `timeout` out 1: one-cycle pulse when the watchdog revokes a grant; tied 0 when the feature is compiled out.

## Operation
- State machine has three states: IDLE, HOLD and GAP.
- Priority pointer `ptr` (2 bits) gives the first index searched. Search order is `ptr`, `ptr+1`, … mod 4.
- IDLE: if any `req` bit is high, grant the first high bit in search order. Set `ptr` = winner+1 mod 4 (3 wraps to 0), clear `hold_cnt`, and go to HOLD. Otherwise stay in IDLE.
- HOLD: `grant` is the winner's bit. `hold_cnt` increments each cycle and saturates at its maximum.
- HOLD exits to GAP when `hold_cnt` ≥ `HOLD_CYCLES`-1 and `req[winner]`=0 on the same edge.
- A request dropped before the minimum hold elapses does not shorten the grant.
- HOLD ignores requests from all other indices; it never preempts.
- GAP lasts exactly one cycle with `grant`=0. From GAP, arbitrate exactly as in IDLE: go to HOLD with a new winner, or go to IDLE if no request is high.
- `req` bits are sampled only on the rising edge; pulses shorter than a cycle are not required to be seen.
- `rst` takes priority over every other event, including mid-grant: state returns to IDLE, `ptr`=0, `hold_cnt`=0, `grant`=4'b0000, `grant_valid`=0, `timeout`=0.

## Timing
- Arbitration latency: `req` sampled high at edge N (in IDLE or GAP) gives `grant` valid after edge N.
- Grant duration: max(`HOLD_CYCLES`, cycles until the winner's `req` is seen low) cycles, followed by one GAP cycle.
- Minimum back-to-back spacing between two grants is exactly one cycle of `grant`=0.
- All outputs are registered; there is no combinational path from `req` to `grant`.
- `hold_cnt` width is `$clog2(MAX_GRANT+1)`.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - In HOLD, when `hold_cnt` reaches `MAX_GRANT`-1, the next edge forces GAP regardless of `req[winner]`.
  - `timeout` pulses high for that GAP cycle only.
  - `ptr` has already advanced past the winner, so a stuck requester cannot starve the others.
- Undefined: no watchdog logic is built, `timeout` is a constant 0, and a grant lasts while its request stays high.

## Test plan
- Reset behaviour: assert `rst` for 2 cycles with `req`=4'b1111 → `grant`=4'b0000, `grant_valid`=0, `timeout`=0 on every cycle of reset.
- Priority from reset: after reset, `req`=4'b1010 → `grant`=4'b0010 one cycle later. When `req[1]` drops after 4 granted cycles → one GAP cycle, then `grant`=4'b1000.
- Round-robin rotation: `req`=4'b1111, with each holder dropping its bit after 4 granted cycles and re-raising it during GAP → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one zero cycle between grants.
- Minimum hold: `HOLD_CYCLES`=4 and a single-cycle pulse on `req[2]` in IDLE → `grant`=4'b0100 for exactly 4 cycles, then 4'b0000.
- Reset mid-grant: assert `rst` during cycle 2 of a `grant`=4'b0100 hold → `grant`=4'b0000 the next cycle. After release with `req`=4'b1111, the first grant is 4'b0001 (`ptr` was reset).
- Watchdog (`ARB_TIMEOUT_EN` defined, `MAX_GRANT`=8): `req`=4'b1001 with `req[0]` stuck high → `grant`=4'b0001 for 8 cycles, then `timeout`=1 for one cycle with `grant`=0, then `grant`=4'b1000.
